// File: rtl/bram_arbiter.sv
// Shared BRAM arbiter: D-priority read port with I starvation guard, D stores on the write port.
// Define BRAM_ARB_FWD_EN to forward same-address store data into a concurrent I read instead of stalling I.
module bram_arbiter #(
    parameter int WIDTH      = 128,
    parameter int DEPTH      = 128,
    parameter int ADDRW      = $clog2(DEPTH),
    parameter int STARVE_MAX = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_req,
    input  logic [ADDRW-1:0]   i_addr,
    output logic               i_gnt,
    output logic               i_rvalid,
    output logic [WIDTH-1:0]   i_rdata,
    input  logic               d_req,
    input  logic               d_we,
    input  logic [WIDTH/8-1:0] d_be,
    input  logic [ADDRW-1:0]   d_addr,
    input  logic [WIDTH-1:0]   d_wdata,
    output logic               d_gnt,
    output logic               d_rvalid,
    output logic [WIDTH-1:0]   d_rdata,
    output logic               bram_ena,
    output logic [WIDTH/8-1:0] bram_wea,
    output logic [ADDRW-1:0]   bram_addra,
    output logic [WIDTH-1:0]   bram_dia,
    output logic               bram_enb,
    output logic [ADDRW-1:0]   bram_addrb,
    input  logic [WIDTH-1:0]   bram_dob
);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int NB = WIDTH / 8;

    logic [SW-1:0] starve_cnt;
    logic          starved;
    logic          d_load;
    logic          d_store;
    logic          hazard;
    logic          i_ok;
    logic          d_load_gnt;
    logic          d_store_gnt;
    logic [WIDTH-1:0] i_merged;

    assign starved = (starve_cnt == SW'(STARVE_MAX));
    assign d_load  = d_req & ~d_we;
    assign d_store = d_req & d_we;
    assign hazard  = i_req & d_store & (i_addr == d_addr);

`ifdef BRAM_ARB_FWD_EN
    assign i_ok = i_req;
`else
    // Without forwarding, the I read waits one cycle so it sees post-write data.
    assign i_ok = i_req & ~hazard;
`endif

    // Grants are forced low while reset is asserted.
    assign i_gnt       = rst_n & i_ok & (~d_load | starved);
    assign d_load_gnt  = rst_n & d_load & ~i_gnt;
    assign d_store_gnt = rst_n & d_store;
    assign d_gnt       = d_load_gnt | d_store_gnt;

    assign bram_ena   = d_store_gnt;
    assign bram_wea   = d_store_gnt ? d_be    : '0;
    assign bram_addra = d_store_gnt ? d_addr  : '0;
    assign bram_dia   = d_store_gnt ? d_wdata : '0;

    assign bram_enb   = i_gnt | d_load_gnt;
    assign bram_addrb = i_gnt ? i_addr : (d_load_gnt ? d_addr : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
            i_rvalid   <= 1'b0;
            d_rvalid   <= 1'b0;
        end else begin
            i_rvalid <= i_gnt;
            d_rvalid <= d_load_gnt;
            if (i_gnt)
                starve_cnt <= '0;
            else if (i_req && !starved)
                starve_cnt <= starve_cnt + SW'(1);
        end
    end

`ifdef BRAM_ARB_FWD_EN
    logic             fwd_valid;
    logic [NB-1:0]    fwd_be;
    logic [WIDTH-1:0] fwd_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_valid <= 1'b0;
            fwd_be    <= '0;
            fwd_data  <= '0;
        end else begin
            fwd_valid <= i_gnt & hazard;
            fwd_be    <= d_be;
            fwd_data  <= d_wdata;
        end
    end

    always_comb begin
        i_merged = bram_dob;
        for (int b = 0; b < NB; b++) begin
            if (fwd_valid && fwd_be[b])
                i_merged[b*8 +: 8] = fwd_data[b*8 +: 8];
        end
    end
`else
    assign i_merged = bram_dob;
`endif

    assign i_rdata = i_rvalid ? i_merged : '0;
    assign d_rdata = d_rvalid ? bram_dob : '0;

endmodule
